packet_scheduler: RTL and testbench
===================================

# packet_scheduler

Sequences the backscatter packet encoder: decides when a packet starts, holds the encoder's `trigger` high for exactly one packet duration, then enforces an inter-packet gap before the next start. Sits between the camera-data FIFO (read-side status only) and the encoder's `trigger` input. The encoder pulls FIFO bytes itself; this block never asserts the FIFO read enable.

## Interface
Parameters:
- `PACKET_LEN`, 64: bytes per packet, including header, padding and metadata.
- `BIT_REPEAT`, 24: clock cycles per byte (8 bits × 3 repeats).
- `GAP_CYCLES`, 256: idle cycles between packets; must be ≥1.
- `MIN_FILL`, 8: FIFO level that starts a packet immediately.
- `TIMEOUT`, 4096: wait cycles after which a non-empty FIFO starts a packet anyway.
- `LEVEL_W`, 10: width of `fifo_level`.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-low.
- `enable` in 1: scheduling allowed; level-sensitive.
- `fifo_level` in `LEVEL_W`: current FIFO occupancy in bytes.
- `fifo_empty` in 1: FIFO empty flag.
- `trigger` out 1: to encoder; high for a whole packet.
- `busy` out 1: high in SEND and GAP.
- `pkt_done` out 1: one-cycle pulse at the end of each packet.
- `pkt_count` out 16: packets completed; wraps.

## Operation
- States: IDLE, WAIT, SEND, GAP.
- IDLE:
  - `trigger`=0.
  - `enable`=1 → WAIT.
- WAIT:
  - The wait counter increments each cycle, saturating at `TIMEOUT-1`.
  - Start condition: `fifo_level >= MIN_FILL`, or (`fifo_empty`=0 and wait counter = `TIMEOUT-1`).
  - Start condition true → SEND; the send counter is cleared.
  - `enable`=0 → IDLE. This takes priority over the start condition in the same cycle.
  - An empty FIFO never starts a packet, even after timeout.
  - The wait counter clears on entry to WAIT.
- SEND:
  - `trigger`=1 for exactly `PACKET_LEN*BIT_REPEAT` cycles (1536 at defaults). The counter runs 0..N-1; at N-1 the state moves to GAP.
  - `enable` dropping mid-packet does not abort. The packet always completes, because a short trigger corrupts the frame.
  - FIFO status is ignored in SEND; the encoder pads on underrun.
- GAP:
  - `trigger`=0 for `GAP_CYCLES` cycles.
  - Then → WAIT if `enable`=1, else → IDLE.
- `pkt_done` and the `pkt_count` increment occur on the SEND→GAP transition. `pkt_count` wraps 0xFFFF→0x0000.
- Counter widths use `$clog2` of the largest terminal count plus 1. No truncation of `PACKET_LEN*BIT_REPEAT`.

## Timing
- Reset (async assert, sync release):
  - State = IDLE; all counters = 0.
  - `trigger`=0, `busy`=0, `pkt_done`=0, `pkt_count`=0.
- All outputs are registered.
- Start latency:
  - `trigger` rises on the clock edge that samples the start condition in WAIT.
  - `enable` rising in IDLE takes at least 2 edges to reach `trigger`=1 (IDLE→WAIT, then WAIT→SEND).
- `trigger` high time is exactly N cycles. `trigger` falls, and `pkt_done` pulses high, on the same edge.
- Back-to-back packets: the minimum period is N + `GAP_CYCLES` + 1 cycles (1 WAIT cycle).
- Reset asserted mid-SEND: `trigger` drops asynchronously. The encoder's own trigger-low path clears its packet state. `pkt_count` is not incremented.
- Inputs `fifo_level` and `fifo_empty` are synchronous to `clock`. No CDC is done in this block.

## Structure
- A shared package/header holds:
  - State encodings (2-bit: IDLE=0, WAIT=1, SEND=2, GAP=3).
  - Default `PACKET_LEN`/`BIT_REPEAT`, shared with the encoder so the two cannot disagree.
- Single module. One generic sub-module is natural: `down_counter` (load, decrement, zero flag), instanced for the send, gap and wait timers.
- Expected RTL is roughly 150–250 lines.

## Test plan
- Fill start:
  - Stimulus: `enable`=1, `fifo_level`=8 held.
  - Required: `trigger` high 1536 cycles; `pkt_done` pulse on the falling edge; `pkt_count`=1; next `trigger` rise exactly 256+1 cycles later.
- Timeout start:
  - Stimulus: `fifo_level`=3, `fifo_empty`=0.
  - Required: `trigger` rises 4096 cycles after WAIT entry; with `fifo_empty`=1 throughout, `trigger` never rises.
- Disable mid-packet:
  - Stimulus: `enable`=0 at SEND cycle 500.
  - Required: `trigger` still high for all 1536 cycles; then GAP; then IDLE; no further packet.
- Reset mid-packet:
  - Stimulus: `reset`=0 at SEND cycle 700.
  - Required: `trigger`=0 immediately; `pkt_count`=0; `busy`=0; after release, normal start from IDLE.
- Counter wrap:
  - Stimulus: force `pkt_count`=0xFFFF, complete one packet.
  - Required: `pkt_count`=0x0000, `pkt_done` pulses once.
- Enable/start race:
  - Stimulus: `enable`=0 and `fifo_level`≥8 in the same WAIT cycle.
  - Required: → IDLE, `trigger` stays 0.

Source files
------------

// File: rtl/packet_scheduler_pkg.sv
// Shared definitions for the packet scheduler and the backscatter encoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package packet_scheduler_pkg;

    // Packet geometry shared with the encoder so both sides agree on frame length.
    localparam int DEF_PACKET_LEN = 64;   // bytes per packet incl. header/padding/metadata
    localparam int DEF_BIT_REPEAT = 24;   // cycles per byte: 8 bits x 3 repeats
    localparam int DEF_GAP_CYCLES = 256;  // idle cycles between packets
    localparam int DEF_MIN_FILL   = 8;    // FIFO level that starts a packet at once
    localparam int DEF_TIMEOUT    = 4096; // wait cycles before a partial FIFO is sent anyway
    localparam int DEF_LEVEL_W    = 10;   // FIFO level width

    localparam int PKT_COUNT_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

    // Counter width able to hold a terminal count without truncation.
    function automatic int cnt_width(input int terminal);
        return $clog2(terminal) + 1;
    endfunction

endpackage

// File: rtl/packet_scheduler_down_counter.sv
// Loadable down counter with zero flag; saturates at zero.
// Latency: load/decrement visible one cycle later; zero flag decoded from the register.
// Backpressure: none; decrement is ignored once the count reaches zero.
module packet_scheduler_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over decrement; decrement stops at zero so the flag holds.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/packet_scheduler.sv
// Sequences encoder packets: start on fill/timeout, hold trigger one packet, then gap.
// Latency: trigger rises on the edge sampling the start condition in WAIT (>=2 edges from enable).
// Backpressure: none; a started packet always runs to completion, FIFO status ignored while sending.
module packet_scheduler
    import packet_scheduler_pkg::*;
#(
    parameter int PACKET_LEN = DEF_PACKET_LEN,
    parameter int BIT_REPEAT = DEF_BIT_REPEAT,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int MIN_FILL   = DEF_MIN_FILL,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int LEVEL_W    = DEF_LEVEL_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [LEVEL_W-1:0]     fifo_level,
    input  logic                   fifo_empty,
    output logic                   trigger,
    output logic                   busy,
    output logic                   pkt_done,
    output logic [PKT_COUNT_W-1:0] pkt_count
);

    // Full 32-bit product so the packet length is never truncated.
    localparam int SEND_CYCLES = PACKET_LEN * BIT_REPEAT;
    localparam int SEND_W      = cnt_width(SEND_CYCLES);
    localparam int GAP_W       = cnt_width(GAP_CYCLES);
    localparam int WAIT_W      = cnt_width(TIMEOUT);

    localparam logic [SEND_W-1:0]  SEND_LAST  = SEND_W'(SEND_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [LEVEL_W-1:0] MIN_FILL_L = LEVEL_W'(MIN_FILL);

    sched_state_t state_q, state_d;

    logic send_load, gap_load, wait_load;
    logic send_zero, gap_zero, wait_zero;
    logic send_last;
    logic start_cond;

    logic                   trigger_q;
    logic                   busy_q;
    logic                   pkt_done_q;
    logic [PKT_COUNT_W-1:0] pkt_count_q;

    // Send timer: loaded with N-1 on start, reaches zero in the last trigger cycle.
    packet_scheduler_down_counter #(.WIDTH(SEND_W)) u_send_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (send_load),
        .load_val_i (SEND_LAST),
        .dec_i      (state_q == ST_SEND),
        .zero_o     (send_zero)
    );

    // Gap timer: reaches zero in the last idle cycle of the inter-packet gap.
    packet_scheduler_down_counter #(.WIDTH(GAP_W)) u_gap_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (gap_load),
        .load_val_i (GAP_LAST),
        .dec_i      (state_q == ST_GAP),
        .zero_o     (gap_zero)
    );

    // Wait timer counts remaining wait; zero means TIMEOUT-1 cycles have elapsed in WAIT.
    packet_scheduler_down_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (wait_load),
        .load_val_i (WAIT_LAST),
        .dec_i      (state_q == ST_WAIT),
        .zero_o     (wait_zero)
    );

    // An empty FIFO never times out into a packet; a full enough one starts at once.
    assign start_cond = (fifo_level >= MIN_FILL_L) || (!fifo_empty && wait_zero);

    // Next-state logic; disable in WAIT beats a simultaneous start, SEND never aborts.
    always_comb begin
        state_d   = state_q;
        send_load = 1'b0;
        gap_load  = 1'b0;
        wait_load = 1'b0;
        send_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_WAIT;
                    wait_load = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (start_cond) begin
                    state_d   = ST_SEND;
                    send_load = 1'b1;
                end
            end
            ST_SEND: begin
                if (send_zero) begin
                    state_d   = ST_GAP;
                    gap_load  = 1'b1;
                    send_last = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_zero) begin
                    if (enable) begin
                        state_d   = ST_WAIT;
                        wait_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops trigger immediately and never counts a packet.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            trigger_q   <= 1'b0;
            busy_q      <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q    <= state_d;
            trigger_q  <= (state_d == ST_SEND);
            busy_q     <= (state_d == ST_SEND) || (state_d == ST_GAP);
            pkt_done_q <= send_last;
            if (send_last) begin
                pkt_count_q <= pkt_count_q + PKT_COUNT_W'(1);
            end
        end
    end

    assign trigger   = trigger_q;
    assign busy      = busy_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed + randomized bench for packet_scheduler against a timing model of the scheduling rules.
module tb_packet_scheduler;

    localparam int N    = 64 * 24;
    localparam int GAP  = 256;
    localparam int TMO  = 4096;
    localparam int MINF = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [9:0]  fifo_level;
    logic        fifo_empty;
    logic        trigger;
    logic        busy;
    logic        pkt_done;
    logic [15:0] pkt_count;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_cnt;

    packet_scheduler #(
        .PACKET_LEN (64),
        .BIT_REPEAT (24),
        .GAP_CYCLES (GAP),
        .MIN_FILL   (MINF),
        .TIMEOUT    (TMO),
        .LEVEL_W    (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .fifo_level (fifo_level),
        .fifo_empty (fifo_empty),
        .trigger    (trigger),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .pkt_count  (pkt_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Follows a packet already hi0 cycles into SEND through its gap; checks length, pulse, count, gap.
    task automatic finish_packet(input int hi0, input string tag);
        int hi;
        int done_hi;
        int g;
        int guard;
        hi = hi0;
        done_hi = 0;
        g = 0;
        guard = 0;
        while (trigger === 1'b1 && guard < N + 16) begin
            if (pkt_done === 1'b1) done_hi++;
            tick();
            guard++;
            if (trigger === 1'b1) hi++;
        end
        exp_cnt = exp_cnt + 16'd1;
        check({tag, "_high_cycles"}, 32'(hi), 32'(N));
        check({tag, "_done_while_high"}, 32'(done_hi), 32'd0);
        check({tag, "_done_at_fall"}, 32'(pkt_done), 32'd1);
        check({tag, "_count"}, 32'(pkt_count), 32'(exp_cnt));
        if (busy === 1'b1) g++;
        tick();
        check({tag, "_done_one_cycle"}, 32'(pkt_done), 32'd0);
        if (busy === 1'b1) g++;
        while (busy === 1'b1 && g < GAP + 16) begin
            tick();
            if (busy === 1'b1) g++;
        end
        check({tag, "_gap_cycles"}, 32'(g), 32'(GAP));
    endtask

    // Drives WAIT-state FIFO status and predicts the start cycle from the start rules.
    // mode 0: non-empty below fill; mode 1: always empty; mode 2: random until fill at t_fill.
    task automatic run_wait(input int mode, input int t_fill, input int limit,
                            output int got, output int exp);
        logic [9:0] lv;
        logic       em;
        got = -1;
        exp = -1;
        for (int k = 0; k < limit && got < 0; k++) begin
            case (mode)
                0: begin
                    em = 1'b0;
                    lv = 10'($urandom_range(1, MINF - 1));
                end
                1: begin
                    em = 1'b1;
                    lv = 10'd0;
                end
                default: begin
                    if (k >= t_fill) begin
                        em = 1'b0;
                        lv = 10'($urandom_range(MINF, 1023));
                    end else begin
                        em = ($urandom_range(0, 1) == 1);
                        lv = em ? 10'd0 : 10'($urandom_range(1, MINF - 1));
                    end
                end
            endcase
            fifo_level = lv;
            fifo_empty = em;
            if (exp < 0 && (int'(lv) >= MINF || (!em && k >= TMO - 1))) exp = k;
            tick();
            if (trigger === 1'b1) got = k;
        end
    endtask

    initial begin
        int hi;
        int rises;
        int got;
        int exp;
        int t_fill;

        reset = 1'b0;
        enable = 1'b0;
        fifo_level = 10'd0;
        fifo_empty = 1'b1;
        exp_cnt = 16'd0;

        // Reset state
        repeat (3) tick();
        check("reset_trigger", 32'(trigger), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(pkt_done), 32'd0);
        check("reset_count", 32'(pkt_count), 32'd0);
        reset = 1'b1;
        tick();
        check("idle_trigger", 32'(trigger), 32'd0);

        // Fill start: two edges from enable to trigger, then back-to-back packet
        fifo_level = 10'd8;
        fifo_empty = 1'b0;
        enable = 1'b1;
        tick();
        check("fill_lat_wait_trigger", 32'(trigger), 32'd0);
        check("fill_lat_wait_busy", 32'(busy), 32'd0);
        tick();
        check("fill_start_trigger", 32'(trigger), 32'd1);
        check("fill_start_busy", 32'(busy), 32'd1);
        finish_packet(1, "fill");
        tick();
        check("b2b_rise_after_gap_plus_1", 32'(trigger), 32'd1);

        // Disable at SEND cycle 500: packet completes, then IDLE
        hi = 1;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (trigger === 1'b1) hi++;
        end
        enable = 1'b0;
        finish_packet(hi, "disable");
        rises = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (trigger === 1'b1) rises++;
        end
        check("disable_no_restart", 32'(rises), 32'd0);
        check("disable_idle_busy", 32'(busy), 32'd0);

        // Enable/start race: disable wins over a ready FIFO in WAIT
        enable = 1'b1;
        tick();
        check("race_wait_trigger", 32'(trigger), 32'd0);
        enable = 1'b0;
        tick();
        check("race_trigger", 32'(trigger), 32'd0);
        check("race_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        tick();
        check("race_was_idle", 32'(trigger), 32'd0);
        tick();
        check("race_restart", 32'(trigger), 32'd1);
        enable = 1'b0;
        finish_packet(1, "race");

        // Timeout start with a partial, non-empty FIFO
        fifo_level = 10'd3;
        enable = 1'b1;
        tick();
        run_wait(0, 0, TMO + 100, got, exp);
        check("timeout_start_cycle", 32'(got), 32'(exp));
        enable = 1'b0;
        finish_packet(1, "timeout");

        // Empty FIFO never starts, even past the timeout
        enable = 1'b1;
        tick();
        run_wait(1, 0, 5000, got, exp);
        check("empty_never_starts", 32'(got), 32'(exp));
        enable = 1'b0;
        tick();
        check("empty_exit_busy", 32'(busy), 32'd0);
        check("empty_exit_trigger", 32'(trigger), 32'd0);

        // Randomized FIFO status in WAIT
        for (int r = 0; r < 6; r++) begin
            t_fill = int'($urandom_range(0, 4500));
            enable = 1'b1;
            tick();
            run_wait(2, t_fill, 6000, got, exp);
            check("random_start_cycle", 32'(got), 32'(exp));
            enable = 1'b0;
            finish_packet(1, "random");
        end

        // Reset at SEND cycle 700
        fifo_level = 10'd8;
        fifo_empty = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        check("rst_pre_trigger", 32'(trigger), 32'd1);
        repeat (700) tick();
        check("rst_mid_send_trigger", 32'(trigger), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_async_trigger", 32'(trigger), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_count", 32'(pkt_count), 32'd0);
        check("rst_async_done", 32'(pkt_done), 32'd0);
        exp_cnt = 16'd0;
        tick();
        reset = 1'b1;
        tick();
        check("rst_release_wait", 32'(trigger), 32'd0);
        tick();
        check("rst_release_start", 32'(trigger), 32'd1);
        enable = 1'b0;
        finish_packet(1, "rst_after");

        // Packet counter wrap
        enable = 1'b1;
        tick();
        tick();
        check("wrap_start", 32'(trigger), 32'd1);
        force dut.pkt_count_q = 16'hFFFF;
        tick();
        release dut.pkt_count_q;
        exp_cnt = 16'hFFFF;
        enable = 1'b0;
        finish_packet((trigger === 1'b1) ? 2 : 1, "wrap");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
